// File: rtl/replay_scheduler.sv
// replay_scheduler: pointer/FSM controller for the replay buffer; define REPLAY_STATS_EN for event counters
module replay_scheduler #(
    parameter int DEPTH      = 8,
    parameter int AW         = 3,
    parameter int TIMER_W    = 12,
    parameter int TIMEOUT    = 1000,
    parameter int MAX_REPLAY = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tx_req,
    output logic          tx_gnt,
    input  logic          link_rdy,
    input  logic          ack,
    input  logic          nak,
    input  logic [AW-1:0] ack_seq,
    input  logic          retrain_done,
    output logic          buf_we,
    output logic [AW-1:0] buf_wr_addr,
    output logic          buf_oe,
    output logic [AW-1:0] buf_rd_addr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   occupancy,
    output logic          replay_active,
`ifdef REPLAY_STATS_EN
    output logic [15:0]   replay_events,
    output logic [15:0]   timeout_events,
`endif
    output logic          retrain_req
);
    localparam int RW = $clog2(MAX_REPLAY + 1);

    typedef enum logic [1:0] {NORMAL, REPLAY, RETRAIN} state_t;

    state_t state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, send_ptr_q, send_ptr_d, ack_ptr_q, ack_ptr_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RW-1:0] replay_num_q, replay_num_d;
    logic [AW-1:0] offset;
    logic [AW:0] new_ack, sent;
    logic ack_hit, nak_hit, timeout, bump, behind;

    // Outputs and decoded events, combinational from registered state and inputs
    always_comb begin
        occupancy     = wr_ptr_q - ack_ptr_q;
        full          = occupancy == (AW+1)'(DEPTH);
        empty         = occupancy == '0;
        replay_active = state_q == REPLAY;
        retrain_req   = state_q == RETRAIN;
        tx_gnt        = tx_req & ~full & ~retrain_req;
        buf_we        = tx_gnt;
        buf_wr_addr   = wr_ptr_q[AW-1:0];
        buf_oe        = link_rdy & (send_ptr_q != wr_ptr_q) & ~retrain_req;
        buf_rd_addr   = send_ptr_q[AW-1:0];
        offset        = ack_seq - ack_ptr_q[AW-1:0];
        ack_hit       = (ack | nak) & ({1'b0, offset} < occupancy);
        nak_hit       = nak & ack_hit;
        new_ack       = ack_ptr_q + {1'b0, offset} + 1'b1;
        timeout       = (state_q == NORMAL) & (send_ptr_q != ack_ptr_q) & ~ack_hit &
                        (timer_q == TIMER_W'(TIMEOUT - 1));
        bump          = (nak_hit | timeout) & ~retrain_req;
    end

    // Next FSM state: triggers escalate, a finished rewind returns to NORMAL
    always_comb begin
        state_d = state_q;
        if (state_q == RETRAIN)
            state_d = retrain_done ? REPLAY : RETRAIN;
        else if (bump)
            state_d = (replay_num_q == RW'(MAX_REPLAY - 1)) ? RETRAIN : REPLAY;
        else if (state_q == REPLAY && send_ptr_d == wr_ptr_q)
            state_d = NORMAL;
    end

    // Pointer, timer and replay-count updates; an ack never pulls send_ptr backwards
    always_comb begin
        sent         = send_ptr_q + (AW+1)'(buf_oe);
        behind       = (sent - ack_ptr_q) <= {1'b0, offset};
        wr_ptr_d     = wr_ptr_q + (AW+1)'(tx_gnt);
        ack_ptr_d    = ack_hit ? new_ack : ack_ptr_q;
        send_ptr_d   = nak_hit ? new_ack : timeout ? ack_ptr_q : (ack_hit && behind) ? new_ack : sent;
        timer_d      = ((state_q == NORMAL) && (send_ptr_q != ack_ptr_q) && !ack_hit && !timeout) ?
                       timer_q + 1'b1 : '0;
        replay_num_d = bump ? replay_num_q + 1'b1 :
                       (ack_hit || (retrain_req && retrain_done)) ? '0 : replay_num_q;
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= NORMAL;
            wr_ptr_q     <= '0;
            send_ptr_q   <= '0;
            ack_ptr_q    <= '0;
            timer_q      <= '0;
            replay_num_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            send_ptr_q   <= send_ptr_d;
            ack_ptr_q    <= ack_ptr_d;
            timer_q      <= timer_d;
            replay_num_q <= replay_num_d;
        end
    end

`ifdef REPLAY_STATS_EN
    logic [15:0] replay_events_q, replay_events_d, timeout_events_q, timeout_events_d;

    // Saturating event counters
    always_comb begin
        replay_events_d  = replay_events_q + 16'(bump && replay_events_q != 16'hFFFF);
        timeout_events_d = timeout_events_q + 16'(timeout && timeout_events_q != 16'hFFFF);
        replay_events    = replay_events_q;
        timeout_events   = timeout_events_q;
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            replay_events_q  <= '0;
            timeout_events_q <= '0;
        end else begin
            replay_events_q  <= replay_events_d;
            timeout_events_q <= timeout_events_d;
        end
    end
`endif
endmodule

// File: tb/tb_replay_scheduler.sv
// tb_replay_scheduler: directed scoreboard bench for replay_scheduler
module tb_replay_scheduler;
    logic clk = 0, reset = 1, tx_req = 0, link_rdy = 0, ack = 0, nak = 0, retrain_done = 0;
    logic [2:0] ack_seq = 0;
    logic tx_gnt, buf_we, buf_oe, full, empty, replay_active, retrain_req;
    logic [2:0] buf_wr_addr, buf_rd_addr;
    logic [3:0] occupancy;
    int checks = 0, passes = 0;
    int exp_we[$], exp_oe[$];

    always #5 clk = ~clk;

    replay_scheduler dut (
        .clk(clk), .reset(reset), .tx_req(tx_req), .tx_gnt(tx_gnt), .link_rdy(link_rdy),
        .ack(ack), .nak(nak), .ack_seq(ack_seq), .retrain_done(retrain_done),
        .buf_we(buf_we), .buf_wr_addr(buf_wr_addr), .buf_oe(buf_oe), .buf_rd_addr(buf_rd_addr),
        .full(full), .empty(empty), .occupancy(occupancy),
        .replay_active(replay_active), .retrain_req(retrain_req)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input bit is_we, input int first, input int n);
        for (int i = 0; i < n; i++)
            if (is_we) exp_we.push_back((first + i) % 8);
            else exp_oe.push_back((first + i) % 8);
    endtask

    task automatic pulse(input logic a, input logic n, input int seq);
        ack = a;
        nak = n;
        ack_seq = 3'(seq);
        cyc();
        ack = 0;
        nak = 0;
    endtask

    // Monitor: every write/transmit strobe must match the next expected address
    always @(negedge clk) begin
        if (!reset && buf_we) begin
            if (exp_we.size() == 0) chk("we_unexpected", int'(buf_wr_addr), -1);
            else chk("we_addr", int'(buf_wr_addr), exp_we.pop_front());
        end
        if (!reset && buf_oe) begin
            if (exp_oe.size() == 0) chk("oe_unexpected", int'(buf_rd_addr), -1);
            else chk("oe_addr", int'(buf_rd_addr), exp_oe.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_empty", int'(empty), 1);
        chk("rst_occ", int'(occupancy), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_flags", int'({replay_active, retrain_req, tx_gnt, buf_oe}), 0);
        cyc();
        reset = 0;
        // three packets written and streamed out
        push_seq(1, 0, 3);
        push_seq(0, 0, 3);
        tx_req = 1; link_rdy = 1;
        repeat (3) cyc();
        tx_req = 0;
        cyc();
        link_rdy = 0;
        @(negedge clk);
        chk("t1_occ", int'(occupancy), 3);
        chk("t1_oe_drained", exp_oe.size(), 0);
        // valid ack, then an out-of-window ack
        pulse(1, 0, 1);
        @(negedge clk);
        chk("t2_occ_ack", int'(occupancy), 1);
        pulse(1, 0, 6);
        @(negedge clk);
        chk("t2_occ_ignored", int'(occupancy), 1);
        pulse(1, 0, 2);
        @(negedge clk);
        chk("t2_empty", int'(empty), 1);
        // fill to DEPTH with the link stalled
        push_seq(1, 3, 8);
        tx_req = 1;
        repeat (7) cyc();
        @(negedge clk);
        chk("t3_occ7", int'(occupancy), 7);
        chk("t3_not_full", int'(full), 0);
        cyc();
        @(negedge clk);
        chk("t3_full", int'(full), 1);
        chk("t3_no_gnt", int'(tx_gnt), 0);
        chk("t3_occ8", int'(occupancy), 8);
        cyc();
        tx_req = 0;
        push_seq(0, 3, 8);
        link_rdy = 1;
        repeat (8) cyc();
        link_rdy = 0;
        pulse(1, 0, 2);
        @(negedge clk);
        chk("t3_drained", int'(empty), 1);
        // nak rewinds to the entry after ack_seq
        push_seq(1, 3, 3);
        push_seq(0, 3, 3);
        tx_req = 1; link_rdy = 1;
        repeat (3) cyc();
        tx_req = 0;
        cyc();
        link_rdy = 0;
        pulse(0, 1, 3);
        @(negedge clk);
        chk("t4_replay", int'(replay_active), 1);
        chk("t4_occ", int'(occupancy), 2);
        push_seq(0, 4, 2);
        link_rdy = 1;
        cyc();
        @(negedge clk);
        chk("t4_still_replay", int'(replay_active), 1);
        cyc();
        link_rdy = 0;
        @(negedge clk);
        chk("t4_normal", int'(replay_active), 0);
        chk("t4_oe_drained", exp_oe.size(), 0);
        pulse(1, 0, 4);
        @(negedge clk);
        chk("t4_occ_after_ack", int'(occupancy), 1);
        // timeouts: two replays, then retrain on the third
        for (int k = 0; k < 3; k++) begin
            repeat (999) cyc();
            @(negedge clk);
            chk("t5_pre_timeout", int'({replay_active, retrain_req}), 0);
            cyc();
            @(negedge clk);
            if (k < 2) begin
                chk("t5_replay", int'(replay_active), 1);
                push_seq(0, 5, 1);
                link_rdy = 1;
                cyc();
                link_rdy = 0;
                @(negedge clk);
                chk("t5_back_normal", int'(replay_active), 0);
            end else begin
                chk("t5_retrain", int'({replay_active, retrain_req}), 1);
                cyc();
                tx_req = 1; link_rdy = 1;
                @(negedge clk);
                chk("t5_retrain_gnt", int'(tx_gnt), 0);
                chk("t5_retrain_oe", int'(buf_oe), 0);
                cyc();
                tx_req = 0; link_rdy = 0; retrain_done = 1;
                cyc();
                retrain_done = 0;
                @(negedge clk);
                chk("t5_done_replay", int'({replay_active, retrain_req}), 2);
                push_seq(0, 5, 1);
                link_rdy = 1;
                cyc();
                link_rdy = 0;
                @(negedge clk);
                chk("t5_done_normal", int'(replay_active), 0);
            end
        end
        // ack+nak together acts as nak; reset aborts the replay
        push_seq(1, 6, 2);
        push_seq(0, 6, 2);
        tx_req = 1; link_rdy = 1;
        repeat (2) cyc();
        tx_req = 0;
        cyc();
        link_rdy = 0;
        @(negedge clk);
        chk("t6_occ3", int'(occupancy), 3);
        pulse(1, 1, 5);
        @(negedge clk);
        chk("t6_nak_wins", int'(replay_active), 1);
        chk("t6_occ2", int'(occupancy), 2);
        cyc();
        reset = 1;
        @(negedge clk);
        chk("t6_rst_empty", int'(empty), 1);
        chk("t6_rst_occ", int'(occupancy), 0);
        chk("t6_rst_normal", int'(replay_active), 0);
        cyc();
        reset = 0;
        link_rdy = 1;
        @(negedge clk);
        chk("t6_no_oe", int'(buf_oe), 0);
        link_rdy = 0;
        cyc();
        chk("end_we_q", exp_we.size(), 0);
        chk("end_oe_q", exp_oe.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
